// File: rtl/s2p_flex_pkg.sv
// Shared helpers for the flexible serial-to-parallel converter: counter sizing
// and beat-to-slice placement.
package s2p_flex_pkg;

  // Counter must represent 0..n inclusive so a full word's count fits.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int slice_index(input int k, input int beats, input bit msb_order);
    return msb_order ? (beats - 1 - k) : k;
  endfunction

endpackage

// File: rtl/s2p_accumulator.sv
// Beat accumulator: places accepted beats into their slice, detects word
// completion and presents the finished word alongside a one-cycle strobe.
module s2p_accumulator
  import s2p_flex_pkg::*;
#(
  parameter int in_w      = 1,
  parameter int n_beats   = 8,
  parameter int msb_first = 0,
  localparam int cnt_w    = count_width(n_beats),
  localparam int out_w    = in_w * n_beats
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic [in_w-1:0]  i_data,
  input  logic             i_last,
  output logic             o_complete,
  output logic [out_w-1:0] o_word,
  output logic [cnt_w-1:0] o_count,
  output logic             o_last
);

  logic [out_w-1:0] r_acc;
  logic [cnt_w-1:0] r_cnt;
  logic [out_w-1:0] w_word;
  logic             w_final;
  int               w_slot;

  // The word seen by the output already includes the beat accepted this cycle,
  // so a completing beat never needs a second pass through the accumulator.
  always_comb begin
    w_slot = slice_index(int'(r_cnt), n_beats, msb_first != 0);
    w_word = r_acc;
    for (int s = 0; s < n_beats; s++) begin
      if (s == w_slot) w_word[s*in_w +: in_w] = i_data;
    end
  end

  assign w_final    = (r_cnt == cnt_w'(n_beats - 1)) || i_last;
  assign o_complete = i_accept && w_final;
  assign o_word     = w_word;
  assign o_count    = r_cnt + cnt_w'(1);
  assign o_last     = i_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      if (w_final) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_word;
        r_cnt <= r_cnt + cnt_w'(1);
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel_flex.sv
// Packs n_beats beats of in_w bits into one word with valid/ready on both
// sides; in_last closes a partial word early.
module serial_to_parallel_flex
  import s2p_flex_pkg::*;
#(
  parameter int in_w      = 1,
  parameter int n_beats   = 8,
  parameter int msb_first = 0,
  localparam int cnt_w    = count_width(n_beats)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [in_w-1:0]         in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [in_w*n_beats-1:0] out_data,
  output logic [cnt_w-1:0]        out_count,
  output logic                    out_last
);

  logic                    w_accept;
  logic                    w_complete;
  logic [in_w*n_beats-1:0] w_word;
  logic [cnt_w-1:0]        w_count;
  logic                    w_last;

  logic                    r_out_valid;
  logic [in_w*n_beats-1:0] r_out_data;
  logic [cnt_w-1:0]        r_out_count;
  logic                    r_out_last;

  // A held word blocks input unless it leaves this same cycle.
  assign in_ready = rst && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  s2p_accumulator #(
    .in_w      (in_w),
    .n_beats   (n_beats),
    .msb_first (msb_first)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_data     (in_data),
    .i_last     (in_last),
    .o_complete (w_complete),
    .o_word     (w_word),
    .o_count    (w_count),
    .o_last     (w_last)
  );

  // Loading has priority over draining so handshake plus completion is bubble-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_count <= w_count;
      r_out_last  <= w_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_last  = r_out_last;

endmodule

// File: doc/serial_to_parallel_flex.md
Name: serial_to_parallel_flex

Overview:
Parametrised successor to the single-bit serial-to-parallel converter. It accepts beats of in_w bits and packs n_beats of them into one output word. It supports LSB- or MSB-first packing, early termination of a partial word via in_last, and valid/ready backpressure on both sides. It sits between narrow serial front-ends and word-wide datapaths.

Parameters:
in_w, 1, bits per input beat
n_beats, 8, beats per full output word; output width = in_w * n_beats
msb_first, 0, 0: first beat lands in the least-significant slice; 1: first beat lands in the most-significant slice
cnt_w, $clog2(n_beats + 1), width of beat counter and out_count (derived, not overridden)

Ports:
clk        input   1                 clock, all logic on rising edge
rst        input   1                 reset
in_valid   input   1                 input beat valid
in_ready   output  1                 input beat accepted when in_valid && in_ready
in_data    input   in_w              beat payload
in_last    input   1                 beat closes the current word (partial or full)
out_valid  output  1                 output word valid
out_ready  input   1                 downstream accepts word when out_valid && out_ready
out_data   output  in_w*n_beats      packed word
out_count  output  cnt_w             number of beats in the word, 1..n_beats
out_last   output  1                 word was closed by in_last

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst): rst == 0 at a rising edge resets.
- Reset state: out_valid=0, out_data=0, out_count=0, out_last=0, accumulator=0, beat count=0.
- in_ready = rst && (!out_valid || out_ready). It is combinational and 0 while in reset.
- Accepted beat number k (0-based within the word) is written to slice k*in_w +: in_w when msb_first=0, or to slice (n_beats-1-k)*in_w +: in_w when msb_first=1.
- A word completes on an accepted beat when k == n_beats-1 or in_last == 1.
- On completion at edge T, from T+1: out_valid=1, out_data = packed word with unfilled slices 0, out_count=k+1, out_last=in_last. The accumulator and count clear at the same edge.
- Latency: the final beat is accepted at edge T and the word is visible in the cycle after T. Sustained throughput is one beat per cycle while out_ready=1.
- While out_valid && !out_ready: out_data, out_count and out_last are held stable, and in_ready=0.
- Output handshake at edge T with no completing beat: out_valid=0 from T+1. out_data keeps its last value; downstream must not use it.
- Output handshake and a completing beat at the same edge: the new word is loaded and out_valid stays 1, with no bubble.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- in_last on beat k=n_beats-1: full word, out_count=n_beats, out_last=1.
- Reset mid-word discards the partial accumulator. Reset while out_valid=1 drops the pending word.
- Conservation: the sum of out_count over handshaken words equals the number of accepted beats.

Decomposition:
- Package s2p_flex_pkg: function count_width(n) returning $clog2(n+1), and a slice_index(k, n_beats, msb_first) helper.
- Sub-module s2p_accumulator: beat counter, slice write, completion detect, and emission of the word/count/last with a one-cycle "complete" strobe.
- Top level: holding register, out_valid, and in_ready logic.

Test Plan:
- in_w=1, n_beats=8, msb_first=0; beats 1,0,1,0,1,0,1,0 back-to-back with out_ready=1 -> one cycle after the 8th beat: out_valid=1, out_data=8'h55, out_count=8, out_last=0.
- Same beats with msb_first=1 -> out_data=8'hAA, out_count=8.
- in_w=4, n_beats=2, msb_first=0; beats 4'h3 then 4'hC -> out_data=8'hC3. Then beats 4'h5 and 4'hA with in_last on the second -> 8'hA5, out_count=2, out_last=1.
- in_w=1, n_beats=8; beats 1,1,1 with in_last on the third -> out_data=8'h07, out_count=3, out_last=1. The next word starts at slice 0.
- Backpressure: complete a word with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready=0. Raise out_ready while a completing beat is pending -> back-to-back words with no bubble.
- Reset mid-word: accept 5 beats, then drive rst=0 for 1 cycle -> all outputs 0. The next 8 beats 1,0,1,0,1,0,1,0 produce 8'h55 with no residue.
- Random: 1000 beats with random in_valid, in_last and out_ready -> scoreboard queue matches every word, and the sum of out_count equals the accepted beat count.
